pci_bus_agent: RTL
==================

# pci_bus_agent

Parametrised PCI-style bus agent that acts as both initiator and target on a shared multi-drop bus. The bus signals are frame_n, irdy_n, trdy_n, devsel_n, ad and c_be. As initiator it requests the bus, runs a burst read or write of 1..2^BURST_W data phases against a remote address, and reports completion or master abort. As target it decodes its own address and serves bursts from a local word memory. It supersedes the fixed 32-bit/32-word device, adding reset, active-low handshakes, wait-state handshaking, wrap-around indexing and master abort.

## Interface
- DATA_W, 32, width of ad, addresses and memory words
- MEM_DEPTH, 32, local memory words; power of two
- BURST_W, 5, width of burst_len
- clock  in  1  single clock; all sampling and driving on posedge
- reset_n  in  1  asynchronous, active-low reset
- frame_n, irdy_n, trdy_n, devsel_n  inout  1 each  active-low bus controls; released (z) when not owned; bench pulls up
- ad  inout  DATA_W  multiplexed address/data
- c_be  inout  4  command during address phase; driven 4'b0000 (all bytes enabled) during data phases
- gnt_n  in  1  arbiter grant, active low
- req_n  out  1  bus request, active low
- start  in  1  one-cycle pulse: begin initiator transaction
- target_addr  in  DATA_W  address to contact
- write  in  1  1 = write, 0 = read; sampled with start
- burst_len  in  BURST_W  number of data phases minus one; sampled with start
- my_addr  in  DATA_W  this agent's target address
- busy  out  1  initiator transaction in progress
- done  out  1  one-cycle pulse at end of initiator transaction
- abort  out  1  valid with done; 1 = master abort

## Operation
- Reset: req_n=1, busy=0, done=0, abort=0; all inouts z; both FSMs idle; indices 0; memory not cleared.
- Bus idle: frame_n and irdy_n both sampled !== 0.
- Transfer: a cycle with irdy_n==0 and trdy_n==0.
- Initiator FSM I_IDLE→I_REQ→I_ADDR→I_DATA→I_TURN→I_IDLE.
  - I_IDLE: start latches target_addr, write and burst_len, sets busy, enters I_REQ. start while busy is ignored.
  - I_REQ: req_n=0. Holds until gnt_n==0 and bus idle, then I_ADDR. Loss of gnt_n here keeps it waiting.
  - I_ADDR (1 cycle): frame_n=0, ad=target_addr, c_be=CMD_WRITE/CMD_READ, req_n=1.
  - I_DATA: irdy_n=0, c_be=4'b0000.
    - Write: drives ad=mem[idx].
    - Read: releases ad and captures ad into mem[idx] on each transfer.
    - idx advances on each transfer, modulo MEM_DEPTH.
    - frame_n goes 1 during the final data phase (remaining==1, including a single-phase burst).
    - Master abort: devsel_n not sampled 0 within ABORT_TIMEOUT=4 cycles of I_ADDR → I_TURN with abort=1.
    - Loss of gnt_n mid-burst is ignored; the burst completes.
  - I_TURN (1 cycle): drives frame_n=1 and irdy_n=1, then releases them; pulses done; clears busy.
- Target FSM T_IDLE→T_WAIT→T_DATA→T_TURN.
  - Decode: in T_IDLE, frame_n 1→0 edge with ad==my_addr and c_be∈{CMD_READ, CMD_WRITE} latches the command and sets idx=0.
  - devsel_n=0 from the next cycle.
  - Write command: captures ad into mem[idx] on each transfer.
  - Read command: drives ad=mem[idx], advancing on each transfer.
  - End of burst: a transfer with frame_n==1 is the last; then T_TURN drives devsel_n=1 and trdy_n=1 for 1 cycle, then releases.
  - The agent never decodes its own initiator transaction.
- Memory: a single array shared by both FSMs; accesses by the two FSMs never overlap in time.

## Timing
- start at posedge N → req_n=0 after N+1.
- gnt_n and bus idle sampled at edge M → frame_n/ad/c_be address phase valid after M.
- Target: address sampled at M+1 → devsel_n=0 after M+1. trdy_n=0 after M+1, or after M+3 under PCI_AGENT_WAIT_EN.
- Irdy_n is low from the first data cycle; one word moves per cycle once both ready signals are low.
- Burst of L phases, no waits: done pulses 1 cycle after the last transfer.
- Reset assertion mid-burst releases all bus lines immediately (asynchronous); the transaction is dropped and done does not pulse.

## Configuration
- PCI_AGENT_WAIT_EN defined: target inserts 2 initial wait states (trdy_n held 1 while devsel_n=0) before the first data phase of every transaction.
- Undefined: trdy_n asserts together with devsel_n.

## Structure
- Package pci_agent_pkg:
  - CMD_READ=4'b1010, CMD_WRITE=4'b0101
  - ABORT_TIMEOUT=4
  - initiator and target state enums
- Sub-module pci_agent_mem: MEM_DEPTH×DATA_W register array, one write port plus one combinational read port, index width $clog2(MEM_DEPTH).

## Test plan
- Bench setup: two agents A (my_addr 0x0000_AAAA) and B (my_addr 0x0000_5555), pullups on all controls, bench arbiter.
- A write, burst_len=3 to B, A mem[0..3]=1,2,3,4 → B mem[0..3]=1,2,3,4; done with abort=0; four transfers.
- A read, burst_len=0 from B mem[0]=0xDEAD_BEEF → A mem[0]=0xDEAD_BEEF; frame_n high during the only data phase.
- A write to unused 0x1234 → no devsel_n; done and abort=1 five cycles after the address phase; bus released.
- Wrap: MEM_DEPTH=4, write burst_len=5 → B mem[0]/mem[1] hold words 5/6.
- Reset_n pulsed mid-burst → all lines z within the cycle; busy=0, req_n=1; next start completes normally.
- PCI_AGENT_WAIT_EN build: trdy_n first low 2 cycles after devsel_n; data intact.

Source files
------------

// File: rtl/pci_agent_pkg.sv
// Shared constants and state encodings for the PCI-style bus agent.
package pci_agent_pkg;
  localparam logic [3:0] CMD_READ      = 4'b1010;
  localparam logic [3:0] CMD_WRITE     = 4'b0101;
  localparam int         ABORT_TIMEOUT = 4;

  typedef enum logic [2:0] {
    I_IDLE = 3'd0,
    I_REQ  = 3'd1,
    I_ADDR = 3'd2,
    I_DATA = 3'd3,
    I_TURN = 3'd4
  } istate_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_DATA = 2'd2,
    T_TURN = 2'd3
  } tstate_e;
endpackage

// File: rtl/pci_agent_mem.sv
// Local word memory shared by initiator and target: one write port, one async read port.
module pci_agent_mem #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pci_bus_agent.sv
// PCI-style initiator + target agent on a shared tri-state bus.
// Define PCI_AGENT_WAIT_EN to make the target insert 2 wait states before its first data phase.
module pci_bus_agent #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int BURST_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  inout  wire               frame_n,
  inout  wire               irdy_n,
  inout  wire               trdy_n,
  inout  wire               devsel_n,
  inout  wire  [DATA_W-1:0] ad,
  inout  wire  [3:0]        c_be,
  input  logic              gnt_n,
  output logic              req_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target_addr,
  input  logic              write,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0] my_addr,
  output logic              busy,
  output logic              done,
  output logic              abort
);
  import pci_agent_pkg::*;

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  istate_e           r_ist;
  tstate_e           r_tst;
  logic [DATA_W-1:0] r_taddr;
  logic              r_wr;
  logic [BURST_W:0]  r_rem;
  logic [AW-1:0]     r_iidx;
  logic [AW-1:0]     r_tidx;
  logic [2:0]        r_to;
  logic              r_dev_seen;
  logic              r_abort;
  logic              r_twr;
  logic              r_frame_q;
`ifdef PCI_AGENT_WAIT_EN
  logic              r_wcnt;
`endif

  logic              w_bus_idle, w_i_addr, w_i_data, w_i_turn, w_i_last, w_i_xfer;
  logic              w_t_own, w_t_data, w_t_xfer, w_decode;
  logic              w_mem_we;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_bus_idle = frame_n & irdy_n;
  assign w_i_addr   = (r_ist == I_ADDR);
  assign w_i_data   = (r_ist == I_DATA);
  assign w_i_turn   = (r_ist == I_TURN);
  assign w_i_last   = (r_rem == {{BURST_W{1'b0}}, 1'b1});
  assign w_i_xfer   = w_i_data && (trdy_n == 1'b0);
  assign w_t_own    = (r_tst != T_IDLE);
  assign w_t_data   = (r_tst == T_DATA);
  assign w_t_xfer   = w_t_data && (irdy_n == 1'b0);
  // Our own address phase must never be decoded by our own target.
  assign w_decode   = (r_tst == T_IDLE) && !w_i_addr && r_frame_q && (frame_n == 1'b0) &&
                      (ad == my_addr) && ((c_be == CMD_READ) || (c_be == CMD_WRITE));

  // The two FSMs never use memory at the same time, so one port pair is muxed by owner.
  assign w_idx    = w_i_data ? r_iidx : r_tidx;
  assign w_mem_we = (w_i_xfer && !r_wr) || (w_t_xfer && r_twr);

  pci_agent_mem #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (ad),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ist      <= I_IDLE;
      r_taddr    <= '0;
      r_wr       <= 1'b0;
      r_rem      <= '0;
      r_iidx     <= '0;
      r_to       <= '0;
      r_dev_seen <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      case (r_ist)
        I_IDLE: if (start) begin
          r_taddr <= target_addr;
          r_wr    <= write;
          r_rem   <= {1'b0, burst_len} + 1'b1;
          r_iidx  <= '0;
          r_abort <= 1'b0;
          r_ist   <= I_REQ;
        end
        I_REQ: if (!gnt_n && w_bus_idle) r_ist <= I_ADDR;
        I_ADDR: begin
          r_to       <= '0;
          r_dev_seen <= 1'b0;
          r_ist      <= I_DATA;
        end
        I_DATA: begin
          if (devsel_n == 1'b0) r_dev_seen <= 1'b1;
          if (w_i_xfer) begin
            r_iidx <= r_iidx + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (w_i_last) r_ist <= I_TURN;
          end else if ((devsel_n != 1'b0) && !r_dev_seen) begin
            if (r_to == 3'(ABORT_TIMEOUT - 1)) begin
              r_abort <= 1'b1;
              r_ist   <= I_TURN;
            end else begin
              r_to <= r_to + 1'b1;
            end
          end
        end
        I_TURN:  r_ist <= I_IDLE;
        default: r_ist <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tst     <= T_IDLE;
      r_tidx    <= '0;
      r_twr     <= 1'b0;
      r_frame_q <= 1'b1;
`ifdef PCI_AGENT_WAIT_EN
      r_wcnt    <= 1'b0;
`endif
    end else begin
      r_frame_q <= frame_n;
      case (r_tst)
        T_IDLE: if (w_decode) begin
          r_twr  <= (c_be == CMD_WRITE);
          r_tidx <= '0;
`ifdef PCI_AGENT_WAIT_EN
          r_wcnt <= 1'b0;
          r_tst  <= T_WAIT;
`else
          r_tst  <= T_DATA;
`endif
        end
`ifdef PCI_AGENT_WAIT_EN
        T_WAIT: if (r_wcnt) r_tst <= T_DATA;
                else        r_wcnt <= 1'b1;
`endif
        T_DATA: if (w_t_xfer) begin
          r_tidx <= r_tidx + 1'b1;
          if (frame_n == 1'b1) r_tst <= T_TURN;
        end
        T_TURN:  r_tst <= T_IDLE;
        default: r_tst <= T_IDLE;
      endcase
    end
  end

  // Drivers derive from state only, so an async reset releases the bus at once.
  assign frame_n  = (w_i_addr || w_i_data || w_i_turn) ? (w_i_data ? w_i_last : w_i_turn) : 1'bz;
  assign irdy_n   = (w_i_data || w_i_turn) ? w_i_turn : 1'bz;
  assign c_be     = w_i_addr ? (r_wr ? CMD_WRITE : CMD_READ) :
                    w_i_data ? 4'b0000 : 4'bzzzz;
  assign ad       = w_i_addr                 ? r_taddr :
                    (w_i_data && r_wr)       ? w_rdata :
                    (w_t_data && !r_twr)     ? w_rdata : {DATA_W{1'bz}};
  assign devsel_n = w_t_own ? (r_tst == T_TURN) : 1'bz;
  assign trdy_n   = w_t_own ? !w_t_data : 1'bz;

  assign req_n = (r_ist != I_REQ);
  assign busy  = (r_ist != I_IDLE);
  assign done  = w_i_turn;
  assign abort = w_i_turn && r_abort;
endmodule
